fetch_unit: RTL and testbench

- Instruction fetch stage for the RV32I core.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel; memory responses return in order.
- Buffers fetched words in a small FIFO and presents {instr, instr_pc} to decode (ImmGen, control, regfile) with a valid/ready handshake.
- Accepts redirects from execute (taken branch, jal, jalr) and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; owns the PC, issues in-order word requests, buffers responses for decode
//   clk, rst                      clock, async active-high reset
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data           in-order responses, no backpressure
//   redirect_valid/pc             one-cycle redirect from execute
//   instr_valid/ready, instr, instr_pc   head of the instruction buffer to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, deliver_pc_q, deliver_pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   mem_q [BUF_DEPTH];
    logic          req_fire, push, pop;
    logic [31:0]   redirect_tgt;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;

    always_comb state_d = RUN;

    // Credits cover both in-flight and buffered words, so the buffer can never overflow.
    always_comb begin
        imem_req_valid = (state_q == RUN) && ({1'b0, out_q} + {1'b0, cnt_q} < DEPTH_W) && !redirect_valid;
        instr_valid    = (cnt_q != '0) && !redirect_valid;
    end

    assign imem_req_addr = fetch_pc_q;
    assign instr         = mem_q[rd_q];
    assign instr_pc      = deliver_pc_q;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign pop           = instr_valid && instr_ready;
    // Responses to requests issued before a redirect are stale and must never reach decode.
    assign push          = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign redirect_tgt  = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        fetch_pc_d   = redirect_valid ? redirect_tgt : req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        deliver_pc_d = redirect_valid ? redirect_tgt : pop ? deliver_pc_q + 32'd4 : deliver_pc_q;
        out_d        = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d       = redirect_valid ? out_d : drop_q - CW'(imem_rsp_valid && (drop_q != '0));
        cnt_d        = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        rd_d         = redirect_valid ? '0 : rd_q + PW'(pop);
        wr_d         = redirect_valid ? '0 : wr_q + PW'(push);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            deliver_pc_q <= RESET_PC;
            out_q        <= '0;
            drop_q       <= '0;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            mem_q        <= '{default: '0};
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            deliver_pc_q <= deliver_pc_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            if (push) mem_q[wr_q] <= imem_rsp_data;
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checking of fetch_unit against a queue-based model
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc;

    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

    req_t        inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] req_log[$], del_log[$], dat_log[$];
    logic [31:0] fetch_pc_m, rpc;
    bit          boot_m, rnd, rdy, irdy, redir, last_iv;
    int          cyc, lat, n_chk, n_err;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RPC);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, RPC);
    endtask

    // One clock: drive inputs, compare against the model, then advance the model past the edge.
    task automatic cycle();
        bit   rsp, erv, eiv;
        int   l;
        req_t e;
        rsp = inflight.size() > 0 && inflight[0].due <= cyc && (!rnd || $urandom_range(0, 3) != 0);
        imem_req_ready = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(inflight[0].addr) : $urandom;
        #1;
        erv = !boot_m && (inflight.size() + fifo_m.size() < DEPTH) && !redir;
        eiv = fifo_m.size() != 0 && !redir;
        chk("req_valid", 32'(imem_req_valid), 32'(erv));
        chk("req_addr", imem_req_addr, fetch_pc_m);
        chk("instr_valid", 32'(instr_valid), 32'(eiv));
        if (eiv) begin
            chk("instr", instr, fifo_m[0].data);
            chk("instr_pc", instr_pc, fifo_m[0].pc);
        end
        last_iv = instr_valid;
        if (eiv && irdy) begin
            del_log.push_back(fifo_m[0].pc);
            dat_log.push_back(fifo_m[0].data);
            void'(fifo_m.pop_front());
        end
        if (rsp) begin
            e = inflight.pop_front();
            if (!e.stale && !redir) fifo_m.push_back('{mem_word(e.addr), e.addr});
        end
        if (erv && rdy) begin
            l = rnd ? int'($urandom_range(1, 4)) : lat;
            inflight.push_back('{fetch_pc_m, 1'b0, cyc + l});
            req_log.push_back(fetch_pc_m);
            fetch_pc_m += 32'd4;
        end
        if (redir) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fetch_pc_m = rpc & 32'hFFFF_FFFC;
        end
        boot_m = 1'b0;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        inflight.delete();
        fifo_m.delete();
        req_log.delete();
        del_log.delete();
        dat_log.delete();
        fetch_pc_m = RPC;
        boot_m = 1'b1;
        redir = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_reqs(int n, string tag);
        int k = 0;
        while (req_log.size() < n && k < 50) begin cycle(); k++; end
        chk({tag, "_wait_reqs"}, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic redirect_to(logic [31:0] pc);
        rpc = pc;
        redir = 1'b1;
        cycle();
        redir = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; lat = 1; rnd = 0;
        rdy = 1; irdy = 1; rpc = 0;
        imem_req_ready = 0; instr_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0;
        #1;
        chk_reset_outputs("por");
        @(negedge clk);

        // Sequential fetch, 1-cycle memory, decode always ready.
        do_reset();
        chk("A_boot_req_valid", 32'(imem_req_valid), 32'd0);
        run(12);
        chk("A_nreq", 32'(req_log.size() >= 3 && del_log.size() >= 3), 32'd1);
        chk("A_req0", req_log[0], 32'h0);
        chk("A_req1", req_log[1], 32'h4);
        chk("A_req2", req_log[2], 32'h8);
        chk("A_pc0", del_log[0], 32'h0);
        chk("A_pc1", del_log[1], 32'h4);
        chk("A_pc2", del_log[2], 32'h8);
        chk("A_dat0", dat_log[0], 32'h0000_FFFF);
        chk("A_dat2", dat_log[2], 32'h0008_FFF7);

        // Decode stalled: credits stop issue at two words.
        do_reset();
        irdy = 0;
        run(10);
        chk("B_nreq", req_log.size(), 32'd2);
        irdy = 1;
        run(1);
        irdy = 0;
        run(8);
        chk("B_nreq_after_pop", req_log.size(), 32'd3);
        chk("B_req2", req_log[2], 32'h8);

        // Memory not ready: address holds.
        do_reset();
        irdy = 1;
        wait_reqs(2, "C");
        rdy = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("C_addr_hold", imem_req_addr, 32'h8);
        end
        rdy = 1;
        wait_reqs(3, "C2");
        chk("C_req2", req_log[2], 32'h8);

        // Redirect with two stale requests in flight.
        do_reset();
        lat = 3;
        wait_reqs(2, "D");
        del_log.delete();
        redirect_to(32'h100);
        run(15);
        chk("D_pc0", del_log[0], 32'h100);
        chk("D_pc1", del_log[1], 32'h104);

        // Misaligned redirect target.
        lat = 1;
        run(4);
        req_log.delete();
        del_log.delete();
        redirect_to(32'h203);
        run(10);
        chk("E_req0", req_log[0], 32'h200);
        chk("E_pc0", del_log[0], 32'h200);

        // Response and redirect in the same cycle.
        begin
            int k = 0;
            while (!(inflight.size() > 0 && inflight[0].due <= cyc) && k < 20) begin cycle(); k++; end
            chk("F_rsp_due", 32'(inflight.size() > 0 && inflight[0].due <= cyc), 32'd1);
        end
        del_log.delete();
        redirect_to(32'h300);
        chk("F_instr_valid", 32'(last_iv), 32'd0);
        run(10);
        chk("F_pc0", del_log[0], 32'h300);
        chk("F_pc1", del_log[1], 32'h304);

        // Randomized traffic.
        rnd = 1;
        for (int k = 0; k < 3000; k++) begin
            rdy   = $urandom_range(0, 3) != 0;
            irdy  = $urandom_range(0, 3) != 0;
            redir = $urandom_range(0, 19) == 0;
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle();
        end
        redir = 0;
        rnd = 0;
        rdy = 1;
        irdy = 1;
        run(5);

        // Asynchronous reset mid-stream, then restart at RESET_PC.
        #2;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk_reset_outputs("G");
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("G_boot_req_valid", 32'(imem_req_valid), 32'd0);
        wait_reqs(1, "G");
        chk("G_req0", req_log[0], RPC);
        run(6);
        chk("G_pc0", del_log[0], RPC);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
